// File: rtl/regfile_wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_arbiter_pkg
//  Description : Shared widths, source numbering and types for the register
//                file writeback arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_wb_arbiter_pkg;

    localparam int C_REG_ADDR_W  = 5;
    localparam int C_REG_DATA_W  = 32;
    localparam int C_REG_NUM     = 32;
    // The main pipeline MEM/WB stage is always writeback source 0.
    localparam int C_WB_SRC_PIPE = 0;

    typedef logic [C_REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [C_REG_DATA_W-1:0] reg_data_t;

    // The winning source's write request after muxing.
    typedef struct packed {
        logic      clr;
        reg_addr_t addr;
        reg_data_t data;
    } wb_write_t;

    // One-hot register mask; r0 never maps to a bit since it cannot be busy.
    function automatic logic [C_REG_NUM-1:0] reg_onehot(input reg_addr_t a);
        logic [C_REG_NUM-1:0] m;
        m    = '0;
        m[a] = (a != '0);
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_arbiter_if
//  Description : Writeback request bus, scoreboard claim/lookup and register
//                file write port, bundled for the writeback arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface regfile_wb_arbiter_if
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int N_REQ = 3
);
    // Writeback sources
    logic [N_REQ-1:0]              req_valid;
    logic [N_REQ-1:0]              req_ready;
    logic [N_REQ*C_REG_ADDR_W-1:0] req_addr;
    logic [N_REQ*C_REG_DATA_W-1:0] req_data;
    logic [N_REQ-1:0]              req_clr;
    // Scoreboard claim from dispatch and lookups from decode
    logic                          claim_valid;
    reg_addr_t                     claim_addr;
    reg_addr_t                     rd_addr1;
    reg_addr_t                     rd_addr2;
    logic                          rd_busy1;
    logic                          rd_busy2;
    // Register file write port
    logic                          rf_we;
    reg_addr_t                     rf_waddr;
    reg_data_t                     rf_wdata;

    // Pipeline side: sources, dispatch, decode and the register file
    modport master (
        output req_valid, req_addr, req_data, req_clr,
        output claim_valid, claim_addr, rd_addr1, rd_addr2,
        input  req_ready, rd_busy1, rd_busy2,
        input  rf_we, rf_waddr, rf_wdata
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_addr, req_data, req_clr,
        input  claim_valid, claim_addr, rd_addr1, rd_addr2,
        output req_ready, rd_busy1, rd_busy2,
        output rf_we, rf_waddr, rf_wdata
    );

endinterface
`default_nettype wire

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin pick over a request vector. The
//                search starts at i_ptr and wraps; the grant is one-hot, or
//                zero when nothing requests.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]                         i_req,
    input  logic [((N > 1) ? $clog2(N) : 1)-1:0] i_ptr,
    output logic [N-1:0]                         o_gnt
);

    logic [N-1:0] w_masked;
    logic         w_hit_hi;
    logic         w_hit_lo;

    // Prefer the lowest request at or above the pointer; otherwise wrap to the
    // lowest request overall.
    always_comb begin
        w_masked = '0;
        o_gnt    = '0;
        w_hit_hi = 1'b0;
        w_hit_lo = 1'b0;
        for (int i = 0; i < N; i++) begin
            w_masked[i] = i_req[i] && (i >= int'(i_ptr));
        end
        for (int i = 0; i < N; i++) begin
            if (!w_hit_hi && w_masked[i]) begin
                o_gnt[i] = 1'b1;
                w_hit_hi = 1'b1;
            end
        end
        if (!w_hit_hi) begin
            for (int i = 0; i < N; i++) begin
                if (!w_hit_lo && i_req[i]) begin
                    o_gnt[i] = 1'b1;
                    w_hit_lo = 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_arbiter
//  Description : Shares the register file write port between the main
//                pipeline (source 0) and multi-cycle units (sources 1..N-1).
//                Source 0 has priority, bounded by a starvation limit; the
//                others are served round-robin. Also tracks a pending-write
//                scoreboard so decode can stall on long-latency results.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int N_REQ      = 3,
    parameter int STARVE_LIM = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wb_arbiter_if.slave  bus
);

    localparam int C_IDX_W  = $clog2(N_REQ);
    localparam int C_N_SUB  = N_REQ - 1;
    localparam int C_SUB_PW = (C_N_SUB > 1) ? $clog2(C_N_SUB) : 1;
    localparam int C_CNT_W  = $clog2(STARVE_LIM + 1);

    localparam logic [C_CNT_W-1:0] C_LIM   = C_CNT_W'(STARVE_LIM);
    localparam logic [C_IDX_W-1:0] C_FIRST = C_IDX_W'(1);
    localparam logic [C_IDX_W-1:0] C_LAST  = C_IDX_W'(N_REQ - 1);

    // Registered state
    logic [C_IDX_W-1:0]   r_rr_ptr;
    logic [C_CNT_W-1:0]   r_starve_cnt;
    logic [C_REG_NUM-1:0] r_busy;
    logic                 r_rf_we;
    reg_addr_t            r_rf_waddr;
    reg_data_t            r_rf_wdata;

    // Combinational arbitration
    logic                 w_others;
    logic                 w_starve;
    logic                 w_pipe_win;
    logic [C_N_SUB-1:0]   w_sub_req;
    logic [C_N_SUB-1:0]   w_sub_gnt;
    logic [C_SUB_PW-1:0]  w_sub_ptr;
    logic [N_REQ-1:0]     w_gnt;
    logic                 w_gnt_any;
    logic [C_IDX_W-1:0]   w_gnt_idx;
    wb_write_t            w_win;
    logic [C_REG_NUM-1:0] w_busy_next;

    assign w_sub_req  = bus.req_valid[N_REQ-1:1];
    assign w_others   = |w_sub_req;
    // Source 0 loses only once it has starved the others for STARVE_LIM grants.
    assign w_starve   = (r_starve_cnt == C_LIM) && w_others;
    assign w_pipe_win = bus.req_valid[C_WB_SRC_PIPE] && !w_starve;
    // rr_ptr counts sources 1..N-1; the sub-arbiter indexes them from 0.
    assign w_sub_ptr  = C_SUB_PW'(r_rr_ptr - C_FIRST);
    assign w_gnt_any  = |w_gnt;

    rr_arbiter #(
        .N (C_N_SUB)
    ) u_rr_arbiter (
        .i_req (w_sub_req),
        .i_ptr (w_sub_ptr),
        .o_gnt (w_sub_gnt)
    );

    // Final grant: nothing during reset, else source 0 or the round-robin pick.
    always_comb begin
        w_gnt = '0;
        if (!rst) begin
            if (w_pipe_win) begin
                w_gnt[C_WB_SRC_PIPE] = 1'b1;
            end else begin
                w_gnt[N_REQ-1:1] = w_sub_gnt;
            end
        end
    end

    // Mux the granted source's request and recover its index.
    always_comb begin
        w_gnt_idx = '0;
        w_win     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt[i]) begin
                w_gnt_idx  = C_IDX_W'(i);
                w_win.clr  = bus.req_clr[i];
                w_win.addr = bus.req_addr[i*C_REG_ADDR_W +: C_REG_ADDR_W];
                w_win.data = bus.req_data[i*C_REG_DATA_W +: C_REG_DATA_W];
            end
        end
    end

    // Scoreboard update: retire on an accepted clearing write, then apply the
    // claim so a same-cycle claim of the same register wins.
    always_comb begin
        w_busy_next = r_busy;
        if (w_gnt_any && w_win.clr) begin
            w_busy_next = w_busy_next & ~reg_onehot(w_win.addr);
        end
        if (bus.claim_valid) begin
            w_busy_next = w_busy_next | reg_onehot(bus.claim_addr);
        end
        w_busy_next[0] = 1'b0;
    end

    // Register file write port: one cycle after the handshake, r0 suppressed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
        end else begin
            r_rf_we <= w_gnt_any && (w_win.addr != '0);
            if (w_gnt_any) begin
                r_rf_waddr <= w_win.addr;
                r_rf_wdata <= w_win.data;
            end
        end
    end

    // Fairness state: starvation counter and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= '0;
            r_rr_ptr     <= C_FIRST;
        end else begin
            if (w_gnt[C_WB_SRC_PIPE] && w_others) begin
                if (r_starve_cnt != C_LIM) begin
                    r_starve_cnt <= r_starve_cnt + 1'b1;
                end
            end else begin
                r_starve_cnt <= '0;
            end
            if (w_gnt_any && !w_gnt[C_WB_SRC_PIPE]) begin
                r_rr_ptr <= (w_gnt_idx == C_LAST) ? C_FIRST : w_gnt_idx + 1'b1;
            end
        end
    end

    // Pending-write scoreboard register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    assign bus.req_ready = w_gnt;
    assign bus.rf_we     = r_rf_we;
    assign bus.rf_waddr  = r_rf_waddr;
    assign bus.rf_wdata  = r_rf_wdata;
    assign bus.rd_busy1  = r_busy[bus.rd_addr1];
    assign bus.rd_busy2  = r_busy[bus.rd_addr2];

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_wb_arbiter
//  Description : Self-checking bench for regfile_wb_arbiter. Expected writes
//                are queued when a grant is expected and popped one cycle
//                later against the register file port.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;
    import regfile_wb_arbiter_pkg::*;

    localparam int N   = 3;
    localparam int LIM = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.N_REQ(N)) bus ();

    regfile_wb_arbiter #(
        .N_REQ      (N),
        .STARVE_LIM (LIM)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    typedef struct packed {
        logic       rst;
        logic [2:0] v;
        logic [2:0] clr;
        logic       cv;
        logic [4:0] ca;
        logic [4:0] rd1;
        logic [4:0] rd2;
        logic       b1;
        logic       b2;
    } step_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad   = 0;

    logic [N-1:0] s_valid;
    logic [4:0]   s_addr[N];
    logic [31:0]  s_data[N];
    logic [N-1:0] s_clr;
    logic         s_claim_v;
    logic [4:0]   s_claim_a;
    logic [4:0]   s_rd1;
    logic [4:0]   s_rd2;

    task automatic apply();
        bus.req_valid   = s_valid;
        bus.req_clr     = s_clr;
        bus.claim_valid = s_claim_v;
        bus.claim_addr  = s_claim_a;
        bus.rd_addr1    = s_rd1;
        bus.rd_addr2    = s_rd2;
        for (int i = 0; i < N; i++) begin
            bus.req_addr[i*5 +: 5]   = s_addr[i];
            bus.req_data[i*32 +: 32] = s_data[i];
        end
    endtask

    // Drive just after the active edge, return at the following falling edge.
    task automatic step_drive(input logic r);
        @(posedge clk);
        #1;
        rst = r;
        apply();
        @(negedge clk);
    endtask

    function automatic exp_t exp_of(input logic [N-1:0] g);
        exp_t e;
        e = '0;
        for (int i = 0; i < N; i++) begin
            if (g[i]) begin
                e.we   = (s_addr[i] != 5'd0);
                e.addr = s_addr[i];
                e.data = s_data[i];
            end
        end
        return e;
    endfunction

    function automatic exp_t pop_exp();
        exp_t e;
        e = '0;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        return e;
    endfunction

    task automatic test_reset();
        exp_q.delete();
        s_valid = '1; s_clr = '0; s_claim_v = 1'b1; s_claim_a = 5'd3;
        s_rd1 = 5'd3; s_rd2 = 5'd3;
        for (int i = 0; i < N; i++) begin
            s_addr[i] = 5'(i + 1);
            s_data[i] = 32'h5000_0000 + i;
        end
        for (int c = 0; c < 2; c++) begin
            step_drive(1'b1);
            total++;
            if (bus.req_ready !== 3'b000) begin
                bad++; $display("FAIL reset ready c%0d: got %b want 000", c, bus.req_ready);
            end
            total++;
            if (bus.rf_we !== 1'b0) begin
                bad++; $display("FAIL reset rf_we c%0d: got %b want 0", c, bus.rf_we);
            end
            total++;
            if ({bus.rd_busy1, bus.rd_busy2} !== 2'b00) begin
                bad++; $display("FAIL reset busy c%0d: got %b%b want 00", c, bus.rd_busy1, bus.rd_busy2);
            end
        end
        exp_q.push_back('0);
        s_valid = '0; s_claim_v = 1'b0;
    endtask

    task automatic test_single_write();
        logic [2:0] v_tab[4];
        exp_t e;
        v_tab = '{3'b001, 3'b010, 3'b100, 3'b000};
        s_addr[0] = 5'd5;  s_data[0] = 32'hDEAD_BEEF;
        s_addr[1] = 5'd12; s_data[1] = 32'h1111_0001;
        s_addr[2] = 5'd13; s_data[2] = 32'h2222_0002;
        s_clr = '0;
        for (int c = 0; c < 4; c++) begin
            s_valid = v_tab[c];
            step_drive(1'b0);
            e = pop_exp();
            total++;
            if (bus.req_ready !== v_tab[c]) begin
                bad++; $display("FAIL single ready c%0d: got %b want %b", c, bus.req_ready, v_tab[c]);
            end
            total++;
            if (bus.rf_we !== e.we || (e.we && (bus.rf_waddr !== e.addr || bus.rf_wdata !== e.data))) begin
                bad++; $display("FAIL single rf c%0d: got we=%b a=%0d d=%h want we=%b a=%0d d=%h",
                                c, bus.rf_we, bus.rf_waddr, bus.rf_wdata, e.we, e.addr, e.data);
            end
            exp_q.push_back(exp_of(v_tab[c]));
        end
    endtask

    task automatic test_starvation();
        int order[11];
        logic [N-1:0] g;
        exp_t e;
        order = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 2, 0};
        s_addr[0] = 5'd1; s_data[0] = 32'hA000_0000;
        s_addr[1] = 5'd2; s_data[1] = 32'hB000_0000;
        s_addr[2] = 5'd3; s_data[2] = 32'hC000_0000;
        s_clr = '0;
        s_valid = 3'b111;
        for (int c = 0; c < 11; c++) begin
            g = '0;
            g[order[c]] = 1'b1;
            step_drive(1'b0);
            e = pop_exp();
            total++;
            if (bus.req_ready !== g) begin
                bad++; $display("FAIL starve ready c%0d: got %b want %b", c, bus.req_ready, g);
            end
            total++;
            if (bus.rf_we !== e.we || (e.we && (bus.rf_waddr !== e.addr || bus.rf_wdata !== e.data))) begin
                bad++; $display("FAIL starve rf c%0d: got we=%b a=%0d d=%h want we=%b a=%0d d=%h",
                                c, bus.rf_we, bus.rf_waddr, bus.rf_wdata, e.we, e.addr, e.data);
            end
            exp_q.push_back(exp_of(g));
            // The granted source moves on to its next write.
            s_data[order[c]] = s_data[order[c]] + 32'd1;
        end
        s_valid = '0;
    endtask

    task automatic test_scoreboard();
        step_t tab[7];
        exp_t  e;
        s_addr[0] = 5'd20; s_data[0] = 32'h0000_0020;
        s_addr[1] = 5'd9;  s_data[1] = 32'h0000_0009;
        s_addr[2] = 5'd7;  s_data[2] = 32'h0000_0007;
        //        rst   v       clr     cv    ca     rd1    rd2    b1    b2
        tab = '{'{1'b0, 3'b000, 3'b000, 1'b1, 5'd7,  5'd7,  5'd8,  1'b0, 1'b0},
                '{1'b0, 3'b000, 3'b000, 1'b0, 5'd0,  5'd7,  5'd8,  1'b1, 1'b0},
                '{1'b0, 3'b100, 3'b100, 1'b0, 5'd0,  5'd7,  5'd9,  1'b1, 1'b0},
                '{1'b0, 3'b010, 3'b010, 1'b1, 5'd9,  5'd7,  5'd9,  1'b0, 1'b0},
                '{1'b0, 3'b000, 3'b000, 1'b0, 5'd0,  5'd7,  5'd9,  1'b0, 1'b1},
                '{1'b0, 3'b000, 3'b000, 1'b1, 5'd9,  5'd9,  5'd7,  1'b1, 1'b0},
                '{1'b0, 3'b000, 3'b000, 1'b0, 5'd0,  5'd9,  5'd7,  1'b1, 1'b0}};
        for (int c = 0; c < 7; c++) begin
            s_valid = tab[c].v; s_clr = tab[c].clr; s_claim_v = tab[c].cv; s_claim_a = tab[c].ca;
            s_rd1 = tab[c].rd1; s_rd2 = tab[c].rd2;
            step_drive(tab[c].rst);
            e = pop_exp();
            total++;
            if (bus.req_ready !== tab[c].v) begin
                bad++; $display("FAIL sb ready c%0d: got %b want %b", c, bus.req_ready, tab[c].v);
            end
            total++;
            if (bus.rf_we !== e.we || (e.we && (bus.rf_waddr !== e.addr || bus.rf_wdata !== e.data))) begin
                bad++; $display("FAIL sb rf c%0d: got we=%b a=%0d d=%h want we=%b a=%0d d=%h",
                                c, bus.rf_we, bus.rf_waddr, bus.rf_wdata, e.we, e.addr, e.data);
            end
            total++;
            if (bus.rd_busy1 !== tab[c].b1) begin
                bad++; $display("FAIL sb busy1 c%0d: got %b want %b", c, bus.rd_busy1, tab[c].b1);
            end
            total++;
            if (bus.rd_busy2 !== tab[c].b2) begin
                bad++; $display("FAIL sb busy2 c%0d: got %b want %b", c, bus.rd_busy2, tab[c].b2);
            end
            exp_q.push_back(exp_of(tab[c].v));
        end
        s_valid = '0; s_clr = '0; s_claim_v = 1'b0;
    endtask

    task automatic test_r0();
        step_t tab[2];
        exp_t  e;
        s_addr[0] = 5'd0; s_data[0] = 32'hABCD_0000;
        //        rst   v       clr     cv    ca     rd1    rd2    b1    b2
        tab = '{'{1'b0, 3'b001, 3'b000, 1'b1, 5'd0,  5'd0,  5'd9,  1'b0, 1'b1},
                '{1'b0, 3'b000, 3'b000, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0}};
        for (int c = 0; c < 2; c++) begin
            s_valid = tab[c].v; s_clr = tab[c].clr; s_claim_v = tab[c].cv; s_claim_a = tab[c].ca;
            s_rd1 = tab[c].rd1; s_rd2 = tab[c].rd2;
            step_drive(tab[c].rst);
            e = pop_exp();
            total++;
            if (bus.req_ready !== tab[c].v) begin
                bad++; $display("FAIL r0 ready c%0d: got %b want %b", c, bus.req_ready, tab[c].v);
            end
            total++;
            if (bus.rf_we !== e.we || (e.we && (bus.rf_waddr !== e.addr || bus.rf_wdata !== e.data))) begin
                bad++; $display("FAIL r0 rf c%0d: got we=%b a=%0d d=%h want we=%b a=%0d d=%h",
                                c, bus.rf_we, bus.rf_waddr, bus.rf_wdata, e.we, e.addr, e.data);
            end
            total++;
            if ({bus.rd_busy1, bus.rd_busy2} !== {tab[c].b1, tab[c].b2}) begin
                bad++; $display("FAIL r0 busy c%0d: got %b%b want %b%b", c,
                                bus.rd_busy1, bus.rd_busy2, tab[c].b1, tab[c].b2);
            end
            exp_q.push_back(exp_of(tab[c].v));
        end
        s_valid = '0; s_claim_v = 1'b0;
    endtask

    task automatic test_reset_mid();
        step_t tab[4];
        logic [2:0] g_tab[4];
        exp_t  e;
        s_addr[0] = 5'd14; s_data[0] = 32'hD000_0000;
        s_addr[1] = 5'd10; s_data[1] = 32'hD111_1111;
        s_addr[2] = 5'd11; s_data[2] = 32'hD222_2222;
        //        rst   v       clr     cv    ca     rd1    rd2    b1    b2
        tab = '{'{1'b0, 3'b010, 3'b000, 1'b1, 5'd4,  5'd4,  5'd9,  1'b0, 1'b1},
                '{1'b1, 3'b110, 3'b000, 1'b0, 5'd0,  5'd4,  5'd9,  1'b1, 1'b1},
                '{1'b0, 3'b110, 3'b000, 1'b0, 5'd0,  5'd4,  5'd9,  1'b0, 1'b0},
                '{1'b0, 3'b000, 3'b000, 1'b0, 5'd0,  5'd4,  5'd9,  1'b0, 1'b0}};
        // After reset rr_ptr is back at source 1, so it beats source 2.
        g_tab = '{3'b010, 3'b000, 3'b010, 3'b000};
        for (int c = 0; c < 4; c++) begin
            s_valid = tab[c].v; s_clr = tab[c].clr; s_claim_v = tab[c].cv; s_claim_a = tab[c].ca;
            s_rd1 = tab[c].rd1; s_rd2 = tab[c].rd2;
            step_drive(tab[c].rst);
            e = pop_exp();
            total++;
            if (bus.req_ready !== g_tab[c]) begin
                bad++; $display("FAIL rstmid ready c%0d: got %b want %b", c, bus.req_ready, g_tab[c]);
            end
            total++;
            if (bus.rf_we !== e.we || (e.we && (bus.rf_waddr !== e.addr || bus.rf_wdata !== e.data))) begin
                bad++; $display("FAIL rstmid rf c%0d: got we=%b a=%0d d=%h want we=%b a=%0d d=%h",
                                c, bus.rf_we, bus.rf_waddr, bus.rf_wdata, e.we, e.addr, e.data);
            end
            total++;
            if ({bus.rd_busy1, bus.rd_busy2} !== {tab[c].b1, tab[c].b2}) begin
                bad++; $display("FAIL rstmid busy c%0d: got %b%b want %b%b", c,
                                bus.rd_busy1, bus.rd_busy2, tab[c].b1, tab[c].b2);
            end
            exp_q.push_back(exp_of(g_tab[c]));
        end
        s_valid = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        s_valid = '0; s_clr = '0; s_claim_v = 1'b0; s_claim_a = '0;
        s_rd1 = '0; s_rd2 = '0;
        for (int i = 0; i < N; i++) begin
            s_addr[i] = '0;
            s_data[i] = '0;
        end
        test_reset();
        test_single_write();
        test_starvation();
        test_scoreboard();
        test_r0();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
